// File: rtl/car_park_lane_counter.sv
// Multi-lane car park entry/exit detector: per-sensor sync + debounce, per-lane
// direction FSM, and a shared saturating occupancy counter with full/empty flags.
module car_park_lane_counter #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CAPACITY = 200,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] sensor_a,
    input  logic [LANES-1:0] sensor_b,
    output logic [LANES-1:0] entered,
    output logic [LANES-1:0] exited,
    output logic [LANES-1:0] seq_err,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    localparam int unsigned NS  = 2 * LANES;
    localparam int unsigned DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned AW  = CNT_W + 4;

    typedef enum logic [2:0] {
        IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, WAIT
    } state_t;

    // Channels [LANES-1:0] are the A sensors, [NS-1:LANES] the B sensors.
    logic [NS-1:0]  raw;
    logic [NS-1:0]  sync1_q;
    logic [NS-1:0]  sync2_q;
    logic [NS-1:0]  filt_q;
    logic [DBW-1:0] dbc_q [NS];

    state_t         st_q [LANES];
    logic [1:0]     p_q  [LANES];

    logic signed [AW-1:0] sum_d;
    logic [CNT_W-1:0]     occ_d;

    assign raw = {sensor_b, sensor_a};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int unsigned s = 0; s < NS; s++) begin
                dbc_q[s] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int unsigned s = 0; s < NS; s++) begin
                if (sync2_q[s] != filt_q[s]) begin
                    if (dbc_q[s] == DBW'(DEBOUNCE - 1)) begin
                        filt_q[s] <= sync2_q[s];
                        dbc_q[s]  <= '0;
                    end else begin
                        dbc_q[s] <= dbc_q[s] + DBW'(1);
                    end
                end else begin
                    dbc_q[s] <= '0;
                end
            end
        end
    end

    // The FSM acts on a registered copy of the filtered pair, so pulses land
    // DEBOUNCE+3 cycles after the raw inputs settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            entered <= '0;
            exited  <= '0;
            seq_err <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                st_q[l] <= IDLE;
                p_q[l]  <= 2'b00;
            end
        end else begin
            entered <= '0;
            exited  <= '0;
            seq_err <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                p_q[l] <= {filt_q[l], filt_q[LANES + l]};
                case (st_q[l])
                    IDLE: case (p_q[l])
                        2'b10: st_q[l] <= ENT1;
                        2'b01: st_q[l] <= EXT1;
                        2'b11: begin seq_err[l] <= 1'b1; st_q[l] <= WAIT; end
                        default: ;
                    endcase
                    ENT1: case (p_q[l])
                        2'b11: st_q[l] <= ENT2;
                        2'b00: st_q[l] <= IDLE;
                        2'b01: begin seq_err[l] <= 1'b1; st_q[l] <= WAIT; end
                        default: ;
                    endcase
                    ENT2: case (p_q[l])
                        2'b01: st_q[l] <= ENT3;
                        2'b10: st_q[l] <= ENT1;
                        2'b00: begin seq_err[l] <= 1'b1; st_q[l] <= IDLE; end
                        default: ;
                    endcase
                    ENT3: case (p_q[l])
                        2'b00: begin entered[l] <= 1'b1; st_q[l] <= IDLE; end
                        2'b11: st_q[l] <= ENT2;
                        2'b10: begin seq_err[l] <= 1'b1; st_q[l] <= WAIT; end
                        default: ;
                    endcase
                    EXT1: case (p_q[l])
                        2'b11: st_q[l] <= EXT2;
                        2'b00: st_q[l] <= IDLE;
                        2'b10: begin seq_err[l] <= 1'b1; st_q[l] <= WAIT; end
                        default: ;
                    endcase
                    EXT2: case (p_q[l])
                        2'b10: st_q[l] <= EXT3;
                        2'b01: st_q[l] <= EXT1;
                        2'b00: begin seq_err[l] <= 1'b1; st_q[l] <= IDLE; end
                        default: ;
                    endcase
                    EXT3: case (p_q[l])
                        2'b00: begin exited[l] <= 1'b1; st_q[l] <= IDLE; end
                        2'b11: st_q[l] <= EXT2;
                        2'b01: begin seq_err[l] <= 1'b1; st_q[l] <= WAIT; end
                        default: ;
                    endcase
                    WAIT: if (p_q[l] == 2'b00) st_q[l] <= IDLE;
                    default: st_q[l] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sum_d = signed'(AW'(occupancy));
        for (int unsigned l = 0; l < LANES; l++) begin
            if (entered[l]) sum_d = sum_d + AW'(1);
            if (exited[l])  sum_d = sum_d - AW'(1);
        end
        if (sum_d < 0) begin
            occ_d = '0;
        end else if (sum_d > signed'(AW'(CAPACITY))) begin
            occ_d = CNT_W'(CAPACITY);
        end else begin
            occ_d = sum_d[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            occupancy <= occ_d;
            full      <= (occ_d == CNT_W'(CAPACITY));
            empty     <= (occ_d == '0);
        end
    end

endmodule

// File: tb/tb_car_park_lane_counter.sv
// Scoreboard bench for car_park_lane_counter (LANES=2, DEBOUNCE=4, CAPACITY=3):
// stimulus queues expected pulses/flags, a negedge monitor pops and compares.
module tb_car_park_lane_counter;

    typedef struct {
        logic [5:0]  pulses;   // {seq_err, exited, entered}
        int unsigned cyc;
        logic [7:0]  occ;
        logic        full;
        logic        empty;
    } exp_t;

    typedef struct {
        logic [7:0] occ;
        logic       full;
        logic       empty;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sensor_a;
    logic [1:0] sensor_b;
    logic [1:0] entered;
    logic [1:0] exited;
    logic [1:0] seq_err;
    logic [7:0] occupancy;
    logic       full;
    logic       empty;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        done = 1'b0;

    exp_t  exp_q[$];
    snap_t snap_q[$];

    logic  occ_pend = 1'b0;
    exp_t  occ_exp;

    car_park_lane_counter #(
        .LANES(2),
        .CNT_W(8),
        .CAPACITY(3),
        .DEBOUNCE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .entered(entered),
        .exited(exited),
        .seq_err(seq_err),
        .occupancy(occupancy),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        logic [5:0] pul;
        exp_t       e;
        snap_t      s;
        pul = {seq_err, exited, entered};
        if (done) begin
            chk("pending_pulses", exp_q.size(), 0);
            chk("pending_snaps", snap_q.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end else if (cyc > 5000) begin
            chk("watchdog", 1, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
        if (occ_pend) begin
            chk("occ_after_pulse", occupancy, occ_exp.occ);
            chk("full_after_pulse", full, occ_exp.full);
            chk("empty_after_pulse", empty, occ_exp.empty);
            occ_pend = 1'b0;
        end
        if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            chk("snap_occ", occupancy, s.occ);
            chk("snap_full", full, s.full);
            chk("snap_empty", empty, s.empty);
            chk("snap_quiet", pul, 0);
        end
        if (pul != 6'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", pul, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_value", pul, e.pulses);
                chk("pulse_cycle", cyc, e.cyc);
                occ_exp  = e;
                occ_pend = 1'b1;
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missing_pulse", 0, e.pulses);
        end
    end

    // Drive both lanes for n cycles; a nonzero pul queues the pulse expected
    // DEBOUNCE+3 = 7 cycles after the first edge sampling these inputs.
    task automatic step(input logic [1:0] a, input logic [1:0] b, input int n,
                        input logic [5:0] pul, input logic [7:0] occ,
                        input logic f, input logic em);
        exp_t e;
        sensor_a = a;
        sensor_b = b;
        if (pul != 6'b0) begin
            e.pulses = pul;
            e.cyc    = cyc + 8;
            e.occ    = occ;
            e.full   = f;
            e.empty  = em;
            exp_q.push_back(e);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] a, input logic [1:0] b, input int n);
        step(a, b, n, 6'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic snap(input logic [7:0] occ, input logic f, input logic em);
        snap_t s;
        s.occ   = occ;
        s.full  = f;
        s.empty = em;
        snap_q.push_back(s);
        @(negedge clk);
    endtask

    // Lane0 entry: P0 = 10,11,01,00.
    task automatic entry0(input logic [7:0] occ, input logic f, input logic em);
        hold(2'b01, 2'b00, 10);
        hold(2'b01, 2'b01, 10);
        hold(2'b00, 2'b01, 10);
        step(2'b00, 2'b00, 12, 6'b000001, occ, f, em);
    endtask

    // Lane1 exit: P1 = 01,11,10,00.
    task automatic exit1(input logic [7:0] occ, input logic f, input logic em);
        hold(2'b00, 2'b10, 10);
        hold(2'b10, 2'b10, 10);
        hold(2'b10, 2'b00, 10);
        step(2'b00, 2'b00, 12, 6'b001000, occ, f, em);
    endtask

    initial begin
        reset    = 1'b1;
        sensor_a = 2'b00;
        sensor_b = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        snap(8'd0, 1'b0, 1'b1);
        hold(2'b00, 2'b00, 20);
        snap(8'd0, 1'b0, 1'b1);

        entry0(8'd1, 1'b0, 1'b0);
        exit1(8'd0, 1'b0, 1'b1);

        // Reversal in ENT2 back to ENT1, then back out: no pulse.
        hold(2'b01, 2'b00, 10);
        hold(2'b01, 2'b01, 10);
        hold(2'b01, 2'b00, 10);
        hold(2'b00, 2'b00, 12);
        snap(8'd0, 1'b0, 1'b1);

        // 3-cycle glitch on sensor_a[0] is filtered out.
        hold(2'b01, 2'b00, 3);
        hold(2'b00, 2'b00, 12);
        snap(8'd0, 1'b0, 1'b1);

        // Jump 00 -> 11: seq_err, then WAIT ignores 10 until 00.
        step(2'b01, 2'b01, 12, 6'b010000, 8'd0, 1'b0, 1'b1);
        hold(2'b01, 2'b00, 12);
        hold(2'b00, 2'b00, 12);
        snap(8'd0, 1'b0, 1'b1);
        entry0(8'd1, 1'b0, 1'b0);
        exit1(8'd0, 1'b0, 1'b1);

        entry0(8'd1, 1'b0, 1'b0);
        entry0(8'd2, 1'b0, 1'b0);
        entry0(8'd3, 1'b1, 1'b0);
        entry0(8'd3, 1'b1, 1'b0);

        // Lane0 entry and lane1 exit terminate together at full: cancel.
        hold(2'b01, 2'b10, 10);
        hold(2'b11, 2'b11, 10);
        hold(2'b10, 2'b01, 10);
        step(2'b00, 2'b00, 12, 6'b001001, 8'd3, 1'b1, 1'b0);

        exit1(8'd2, 1'b0, 1'b0);

        // Reset while lane0 sits in ENT2; the rest of the pass gives no pulse.
        hold(2'b01, 2'b00, 10);
        hold(2'b01, 2'b01, 10);
        reset    = 1'b1;
        sensor_a = 2'b00;
        sensor_b = 2'b01;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        snap(8'd0, 1'b0, 1'b1);
        hold(2'b00, 2'b01, 10);
        hold(2'b00, 2'b00, 12);
        snap(8'd0, 1'b0, 1'b1);

        done = 1'b1;
        forever @(negedge clk);
    end

endmodule

// File: doc/car_park_lane_counter.md
Name: car_park_lane_counter

Overview:
Multi-lane car park entry/exit detector with a shared occupancy counter. Each lane has two beam sensors, A (outer) and B (inner). Per lane, the block synchronises and debounces both sensors, then runs a direction FSM that detects complete entry or exit passes. A central saturating counter tracks occupancy and raises full/empty flags for the barrier and sign controllers.

Parameters:
LANES, 2, number of independent lanes (1..8)
CNT_W, 8, occupancy counter width
CAPACITY, 200, maximum occupancy; must be < 2**CNT_W
DEBOUNCE, 4, consecutive stable cycles required before a filtered sensor changes (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sensor_a  in  LANES  raw outer sensors, 1 = beam blocked, asynchronous to clk
sensor_b  in  LANES  raw inner sensors, 1 = beam blocked, asynchronous to clk
entered  out  LANES  one-cycle pulse per completed entry, per lane
exited  out  LANES  one-cycle pulse per completed exit, per lane
seq_err  out  LANES  one-cycle pulse on an illegal sensor transition, per lane
occupancy  out  CNT_W  current car count
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0

Behaviour:
- Reset (sync, active-high): all sync flops, filtered sensors and debounce counters cleared; every lane FSM goes to IDLE; entered/exited/seq_err = 0; occupancy = 0; full = 0; empty = 1.
- Reset asserted mid-pass aborts the pass with no pulse. After reset releases, counting restarts from 0.
- Input conditioning, per sensor:
  - 2-flop synchroniser.
  - Debounce: per-sensor counter; filtered value takes the synced value once the synced value has differed from the filtered value for DEBOUNCE consecutive cycles.
  - Any mismatch-free cycle clears the counter.
- Lane FSM input is P = {filt_a, filt_b}. The FSM is registered.
- Lane FSM states and transitions:
  - IDLE: 10 -> ENT1; 01 -> EXT1; 11 -> seq_err, go to WAIT.
  - ENT1 (10): 11 -> ENT2; 00 -> IDLE (car backed out, no pulse); 01 -> seq_err, go to WAIT.
  - ENT2 (11): 01 -> ENT3; 10 -> ENT1 (reversal).
  - ENT3 (01): 00 -> IDLE with entered pulse; 11 -> ENT2.
  - EXT1 (01): 11 -> EXT2; 00 -> IDLE (no pulse); 10 -> seq_err, go to WAIT.
  - EXT2 (11): 10 -> EXT3; 01 -> EXT1.
  - EXT3 (10): 00 -> IDLE with exited pulse; 11 -> EXT2.
  - ENT2 on 00 and EXT2 on 00 (double jump): seq_err, go to IDLE.
  - ENT3 on 10 and EXT3 on 01: seq_err, go to WAIT.
  - WAIT: stays until P == 00, then goes to IDLE. No pulses in WAIT.
  - Unlisted P values hold the current state.
- Pulse timing: entered/exited/seq_err are registered. They assert in the cycle after the FSM observes the terminating P and last exactly 1 cycle.
- Latency from raw sensors settling at the final 00: pulse asserts DEBOUNCE+3 cycles after the first clk edge that samples the settled value.
- Occupancy:
  - Updated the cycle after the pulses: occupancy_next = clamp(occupancy + popcount(entered) - popcount(exited), 0, CAPACITY).
  - Internal arithmetic is CNT_W+4 bits wide and signed.
  - Simultaneous entry and exit on different lanes cancel in the same cycle.
- Saturation:
  - Entry at full: entered still pulses; occupancy holds at CAPACITY.
  - Exit at empty: exited still pulses; occupancy holds at 0.
- Flags: full and empty are registered, derived from the updated occupancy, and valid in the same cycle as occupancy.
- Lanes are fully independent. Glitches shorter than DEBOUNCE cycles never reach an FSM.

Test Plan:
- Reset, then hold sensors 00 for 20 cycles (LANES=2, DEBOUNCE=4, CAPACITY=3) -> occupancy=0, empty=1, full=0, no pulses.
- Lane0 sequence 10,11,01,00, each held 10 cycles -> entered[0] high for exactly 1 cycle, 7 cycles after the final 00 edge; occupancy=1 the next cycle; empty=0.
- Lane1 sequence 01,11,10,00 with occupancy=1 -> exited[1] one pulse; occupancy=0; empty=1. Lane0 sequence 10,11,10,00 (reversal) -> no pulse, occupancy unchanged.
- 3-cycle glitch of sensor_a[0] to 1 in IDLE -> no state change, no pulses. Lane0 jump 00 to 11 -> seq_err[0] pulse; FSM stays in WAIT until 00; then a full entry counts normally.
- Four lane0 entries with CAPACITY=3 -> occupancy 1,2,3,3; full=1 after the third; entered pulses all four times. Lane0 entry and lane1 exit terminating on the same cycle at occupancy=3 -> occupancy stays 3.
- Reset asserted while lane0 is in ENT2 with occupancy=2 -> next cycle occupancy=0, empty=1. The remainder of the pass (01,00) produces no entered pulse.
